// File: rtl/eth_pkg.sv
// Ethernet/ARP constants shared by the ARP receiver and transmitter.
package eth_pkg;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IP  = 16'h0800;
  localparam logic [7:0]  ARP_HLEN      = 8'h06;
  localparam logic [7:0]  ARP_PLEN      = 8'h04;
  localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
  localparam logic [15:0] ARP_OP_REP    = 16'h0002;
  localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_WAIT_EOP, ST_DONE} arp_rx_state_e;
endpackage

// File: rtl/arp_rx_stats.sv
// Saturating good/drop frame counters for the ARP receiver.
module arp_rx_stats (
  input  logic        clk_156_25,
  input  logic        rst_n,
  input  logic        good_inc,
  input  logic        drop_inc,
  output logic [15:0] good_cnt,
  output logic [15:0] drop_cnt
);
  logic [15:0] good_q, good_d, drop_q, drop_d;

  always_comb begin
    good_d = good_q;
    drop_d = drop_q;
    if (good_inc && good_q != 16'hFFFF) good_d = good_q + 16'd1;
    if (drop_inc && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk_156_25 or negedge rst_n) begin
    if (!rst_n) begin
      good_q <= '0;
      drop_q <= '0;
    end else begin
      good_q <= good_d;
      drop_q <= drop_d;
    end
  end

  assign good_cnt = good_q;
  assign drop_cnt = drop_q;
endmodule

// File: rtl/arp_recv_from_10gmac.sv
// ARP receiver on a 64-bit Avalon-ST 10G MAC stream; captures header beats 0..5 and
// validates on DONE. Define ARP_RX_STATS_EN to build the good/drop counters.
module arp_recv_from_10gmac
  import eth_pkg::*;
(
  input  logic        clk_156_25,
  input  logic        rst_n,
  input  logic        avalon_st_rx_startofpacket,
  input  logic        avalon_st_rx_valid,
  input  logic        avalon_st_rx_endofpacket,
  output logic        avalon_st_rx_ready,
  input  logic [63:0] avalon_st_rx_data,
  input  logic [2:0]  avalon_st_rx_empty,
  input  logic [5:0]  avalon_st_rx_error,
  input  logic [47:0] local_mac_addr,
  input  logic [31:0] local_ip_addr,
  output logic        arp_rx_done,
  output logic        arp_rx_op,
  output logic [47:0] arp_rx_src_mac,
  output logic [31:0] arp_rx_src_ip,
  output logic [15:0] arp_rx_good_cnt,
  output logic [15:0] arp_rx_drop_cnt
);
  arp_rx_state_e     state_q, state_d;
  logic [2:0]        beat_q, beat_d;
  logic [0:5][63:0]  hdr_q, hdr_d;   // hdr_q[0] holds frame bytes 0..7
  logic [5:0]        err_q, err_d;
  logic              ready_q, done_q, done_d, op_q, op_d;
  logic [47:0]       mac_q, mac_d;
  logic [31:0]       ip_q, ip_d;
  logic              acc, frame_ok, good_pulse, drop_pulse;
  logic [383:0]      hdr_flat;

  assign acc      = avalon_st_rx_valid & ready_q;
  assign hdr_flat = hdr_q;

  // byte n of the frame sits at hdr_flat[383-8n -: 8]
  wire [47:0] f_dst   = hdr_flat[383 -: 48];
  wire [15:0] f_type  = hdr_flat[287 -: 16];
  wire [15:0] f_htype = hdr_flat[271 -: 16];
  wire [15:0] f_ptype = hdr_flat[255 -: 16];
  wire [7:0]  f_hlen  = hdr_flat[239 -: 8];
  wire [7:0]  f_plen  = hdr_flat[231 -: 8];
  wire [15:0] f_op    = hdr_flat[223 -: 16];
  wire [47:0] f_sha   = hdr_flat[207 -: 48];
  wire [31:0] f_spa   = hdr_flat[159 -: 32];
  wire [31:0] f_tpa   = hdr_flat[79 -: 32];

  assign frame_ok = (f_dst == MAC_BROADCAST || f_dst == local_mac_addr) &&
                    f_type == ETH_TYPE_ARP && f_htype == ARP_HTYPE_ETH &&
                    f_ptype == ARP_PTYPE_IP && f_hlen == ARP_HLEN && f_plen == ARP_PLEN &&
                    (f_op == ARP_OP_REQ || f_op == ARP_OP_REP) &&
                    f_tpa == local_ip_addr && err_q == 6'd0;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    hdr_d      = hdr_q;
    err_d      = err_q;
    done_d     = 1'b0;
    op_d       = op_q;
    mac_d      = mac_q;
    ip_d       = ip_q;
    good_pulse = 1'b0;
    drop_pulse = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (acc && avalon_st_rx_startofpacket) begin
          hdr_d    = '0;
          hdr_d[0] = avalon_st_rx_data;
          err_d    = '0;
          beat_d   = 3'd1;
          if (avalon_st_rx_endofpacket) drop_pulse = 1'b1;
          else                          state_d    = ST_HDR;
        end
      end
      ST_HDR, ST_WAIT_EOP: begin
        if (acc) begin
          if (avalon_st_rx_startofpacket) begin
            // restart on the new SOP; the interrupted frame is a drop
            drop_pulse = 1'b1;
            hdr_d      = '0;
            hdr_d[0]   = avalon_st_rx_data;
            err_d      = '0;
            beat_d     = 3'd1;
            state_d    = avalon_st_rx_endofpacket ? ST_IDLE : ST_HDR;
          end else if (state_q == ST_HDR) begin
            hdr_d[beat_q] = avalon_st_rx_data;
            beat_d        = beat_q + 3'd1;
            if (beat_q == 3'd5) begin
              if (avalon_st_rx_endofpacket) begin
                err_d   = avalon_st_rx_error;
                state_d = ST_DONE;
              end else begin
                state_d = ST_WAIT_EOP;
              end
            end else if (avalon_st_rx_endofpacket) begin
              drop_pulse = 1'b1;
              state_d    = ST_IDLE;
            end
          end else if (avalon_st_rx_endofpacket) begin
            err_d   = avalon_st_rx_error;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (frame_ok) begin
          done_d     = 1'b1;
          op_d       = (f_op == ARP_OP_REP);
          mac_d      = f_sha;
          ip_d       = f_spa;
          good_pulse = 1'b1;
        end else begin
          drop_pulse = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_156_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      hdr_q   <= '0;
      err_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= 1'b0;
      mac_q   <= '0;
      ip_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      hdr_q   <= hdr_d;
      err_q   <= err_d;
      ready_q <= 1'b1;
      done_q  <= done_d;
      op_q    <= op_d;
      mac_q   <= mac_d;
      ip_q    <= ip_d;
    end
  end

  assign avalon_st_rx_ready = ready_q;
  assign arp_rx_done        = done_q;
  assign arp_rx_op          = op_q;
  assign arp_rx_src_mac     = mac_q;
  assign arp_rx_src_ip      = ip_q;

`ifdef ARP_RX_STATS_EN
  arp_rx_stats u_stats (
    .clk_156_25 (clk_156_25),
    .rst_n      (rst_n),
    .good_inc   (good_pulse),
    .drop_inc   (drop_pulse),
    .good_cnt   (arp_rx_good_cnt),
    .drop_cnt   (arp_rx_drop_cnt)
  );
`else
  logic unused_stats;
  assign unused_stats    = good_pulse | drop_pulse;
  assign arp_rx_good_cnt = '0;
  assign arp_rx_drop_cnt = '0;
`endif

  // empty, src MAC in the Ethernet header, THA and trailing padding carry no decision
  logic unused_bits;
  assign unused_bits = ^{avalon_st_rx_empty, hdr_flat[335:288], hdr_flat[127:80], hdr_flat[47:0]};
endmodule

// File: tb/tb_arp_recv_from_10gmac.sv
// Bench for arp_recv_from_10gmac: directed vector table, hand sequences, random frames vs byte-level model.
module tb_arp_recv_from_10gmac;
  localparam logic [47:0] LMAC = 48'h0200_0000_0001;
  localparam logic [31:0] LIP  = 32'hC0A8_0102;
  localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SHA0 = 48'h0011_2233_4455;
  localparam logic [31:0] SPA0 = 32'hC0A8_010A;

  logic        clk_156_25 = 1'b0, rst_n = 1'b0;
  logic        sop = 1'b0, valid = 1'b0, eop = 1'b0, ready;
  logic [63:0] data = '0;
  logic [2:0]  empty = '0;
  logic [5:0]  error = '0;
  logic        done, op;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [15:0] good_cnt, drop_cnt;

  always #3 clk_156_25 = ~clk_156_25;

  arp_recv_from_10gmac dut (
    .clk_156_25                 (clk_156_25),
    .rst_n                      (rst_n),
    .avalon_st_rx_startofpacket (sop),
    .avalon_st_rx_valid         (valid),
    .avalon_st_rx_endofpacket   (eop),
    .avalon_st_rx_ready         (ready),
    .avalon_st_rx_data          (data),
    .avalon_st_rx_empty         (empty),
    .avalon_st_rx_error         (error),
    .local_mac_addr             (LMAC),
    .local_ip_addr              (LIP),
    .arp_rx_done                (done),
    .arp_rx_op                  (op),
    .arp_rx_src_mac             (src_mac),
    .arp_rx_src_ip              (src_ip),
    .arp_rx_good_cnt            (good_cnt),
    .arp_rx_drop_cnt            (drop_cnt)
  );

  int n_chk = 0, n_fail = 0;
  logic [7:0]  fb [0:71];
  logic        exp_op = 1'b0;
  logic [47:0] exp_mac = '0;
  logic [31:0] exp_ip = '0;
  int          exp_good = 0, exp_drop = 0;

  typedef struct {
    string       nm;
    logic [47:0] dst;
    logic [15:0] et;
    logic [15:0] opc;
    logic [31:0] tpa;
    logic [5:0]  err;
    bit          exp_done;
    bit          exp_op;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input int c);
`ifdef ARP_RX_STATS_EN
    return (c > 65535) ? 16'hFFFF : 16'(c);
`else
    return (c >= 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  // big-endian field of n bytes starting at frame byte off
  function automatic logic [63:0] get(input int off, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[55:0], fb[off+i]};
    return v;
  endfunction

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] ht,
                       input logic [15:0] pt, input logic [7:0] hl, input logic [7:0] pl,
                       input logic [15:0] opc, input logic [47:0] sha, input logic [31:0] spa,
                       input logic [31:0] tpa);
    logic [335:0] h;
    h = {dst, 48'h00AA_BBCC_DDEE, et, ht, pt, hl, pl, opc, sha, spa, 48'h0, tpa};
    for (int i = 0; i < 42; i++) fb[i] = h[335-8*i -: 8];
    for (int i = 42; i < 72; i++) fb[i] = 8'($urandom);
  endtask

  task automatic build_arp(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] opc,
                           input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
    build(dst, et, 16'h0001, 16'h0800, 8'h06, 8'h04, opc, sha, spa, tpa);
  endtask

  // ARP acceptance decided directly from the frame bytes
  function automatic bit model_ok(input logic [5:0] err, input int nb);
    logic [47:0] d;
    logic [15:0] o;
    d = get(0, 6);
    o = get(20, 2);
    return nb >= 6 && (d == BC || d == LMAC) && get(12, 2) == 64'h0806 &&
           get(14, 2) == 64'h0001 && get(16, 2) == 64'h0800 && get(18, 1) == 64'h06 &&
           get(19, 1) == 64'h04 && (o == 16'h0001 || o == 16'h0002) &&
           get(38, 4) == {32'h0, LIP} && err == 6'd0;
  endfunction

  task automatic drive_beat(input int b, input bit s, input bit e, input logic [5:0] err);
    valid = 1'b1; sop = s; eop = e;
    for (int i = 0; i < 8; i++) data[63-8*i -: 8] = fb[8*b+i];
    empty = e ? 3'd4 : 3'd0;
    error = e ? err : 6'd0;
    @(negedge clk_156_25);
    valid = 1'b0; sop = 1'b0; eop = 1'b0; error = '0; empty = '0;
  endtask

  task automatic send(input int nb, input bit do_eop, input logic [5:0] err, input bit gaps);
    for (int b = 0; b < nb; b++) begin
      if (gaps && b > 0) repeat ($urandom_range(0, 2)) @(negedge clk_156_25);
      drive_beat(b, b == 0, do_eop && b == nb - 1, err);
    end
  endtask

  task automatic chk_outs(input string nm, input bit exp_done);
    chk({nm, ".done"}, 64'(done), 64'(exp_done));
    chk({nm, ".op"}, 64'(op), 64'(exp_op));
    chk({nm, ".src_mac"}, 64'(src_mac), 64'(exp_mac));
    chk({nm, ".src_ip"}, 64'(src_ip), 64'(exp_ip));
    chk({nm, ".good_cnt"}, 64'(good_cnt), 64'(cnt_exp(exp_good)));
    chk({nm, ".drop_cnt"}, 64'(drop_cnt), 64'(cnt_exp(exp_drop)));
  endtask

  // called at the negedge right after the EOP beat edge
  task automatic after_frame(input bit ok, input string nm);
    chk({nm, ".done_early"}, 64'(done), 64'd0);
    @(negedge clk_156_25);
    if (ok) begin
      exp_op  = (get(20, 2) == 64'h0002);
      exp_mac = get(22, 6);
      exp_ip  = get(28, 4);
      exp_good++;
    end else begin
      exp_drop++;
    end
    chk_outs(nm, ok);
    @(negedge clk_156_25);
    chk({nm, ".done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    vec_t        vt [7];
    int          c, nb;
    logic [47:0] dst;
    logic [15:0] et, ht, pt, opc;
    logic [7:0]  hl, pl;
    logic [31:0] tpa;
    logic [5:0]  err;
    bit          ok;

    vt[0] = '{"bcast_req", BC,   16'h0806, 16'h0001, LIP,          6'h00, 1'b1, 1'b0};
    vt[1] = '{"ucast_rep", LMAC, 16'h0806, 16'h0002, LIP,          6'h00, 1'b1, 1'b1};
    vt[2] = '{"wrong_tpa", BC,   16'h0806, 16'h0001, 32'hC0A80163, 6'h00, 1'b0, 1'b0};
    vt[3] = '{"eop_err",   BC,   16'h0806, 16'h0001, LIP,          6'h01, 1'b0, 1'b0};
    vt[4] = '{"type_ip",   BC,   16'h0800, 16'h0001, LIP,          6'h00, 1'b0, 1'b0};
    vt[5] = '{"other_mac", 48'h0200_0000_0002, 16'h0806, 16'h0001, LIP, 6'h00, 1'b0, 1'b0};
    vt[6] = '{"bad_op",    LMAC, 16'h0806, 16'h0003, LIP,          6'h00, 1'b0, 1'b0};

    repeat (3) @(negedge clk_156_25);
    chk("reset.ready", 64'(ready), 64'd0);
    chk_outs("reset", 1'b0);
    rst_n = 1'b1;
    @(negedge clk_156_25);
    chk("ready_after_reset", 64'(ready), 64'd1);

    foreach (vt[i]) begin
      build_arp(vt[i].dst, vt[i].et, vt[i].opc, SHA0, SPA0 + 32'(i), vt[i].tpa);
      send(8, 1'b1, vt[i].err, 1'b0);
      chk({vt[i].nm, ".done_early"}, 64'(done), 64'd0);
      @(negedge clk_156_25);
      if (vt[i].exp_done) begin
        exp_op = vt[i].exp_op; exp_mac = SHA0; exp_ip = SPA0 + 32'(i); exp_good++;
      end else begin
        exp_drop++;
      end
      chk_outs(vt[i].nm, vt[i].exp_done);
      @(negedge clk_156_25);
      chk({vt[i].nm, ".done_width"}, 64'(done), 64'd0);
    end

    // EOP on beat 3, then single SOP+EOP beat
    build_arp(BC, 16'h0806, 16'h0001, 48'h0A0B_0C0D_0E0F, 32'h0A000001, LIP);
    send(4, 1'b1, 6'd0, 1'b0);
    after_frame(1'b0, "short");
    send(1, 1'b1, 6'd0, 1'b0);
    after_frame(1'b0, "sop_eop");

    // frame interrupted by a new SOP, the new one arrives with valid gaps
    build_arp(BC, 16'h0806, 16'h0001, 48'h0A0B_0C0D_0E0F, 32'h0A000001, LIP);
    send(3, 1'b0, 6'd0, 1'b0);
    exp_drop++;
    build_arp(LMAC, 16'h0806, 16'h0002, 48'h0066_7788_99AA, 32'hC0A8010B, LIP);
    send(8, 1'b1, 6'd0, 1'b1);
    after_frame(1'b1, "restart");

    // reset asserted during beat 4, tail of the frame then arrives without SOP
    build_arp(BC, 16'h0806, 16'h0001, SHA0, SPA0, LIP);
    send(4, 1'b0, 6'd0, 1'b0);
    rst_n = 1'b0;
    drive_beat(4, 1'b0, 1'b0, 6'd0);
    exp_op = 1'b0; exp_mac = '0; exp_ip = '0; exp_good = 0; exp_drop = 0;
    chk("rst_mid.ready", 64'(ready), 64'd0);
    chk_outs("rst_mid", 1'b0);
    rst_n = 1'b1;
    @(negedge clk_156_25);
    for (int b = 5; b < 8; b++) drive_beat(b, 1'b0, b == 7, 6'd0);
    @(negedge clk_156_25);
    @(negedge clk_156_25);
    chk_outs("rst_tail", 1'b0);
    send(8, 1'b1, 6'd0, 1'b0);
    after_frame(1'b1, "post_reset");

    for (int n = 0; n < 40; n++) begin
      c   = int'($urandom_range(0, 11));
      nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 9));
      dst = $urandom_range(0, 1) ? BC : LMAC;
      et = 16'h0806; ht = 16'h0001; pt = 16'h0800; hl = 8'h06; pl = 8'h04;
      opc = 16'($urandom_range(1, 2)); tpa = LIP; err = 6'd0;
      case (c)
        0: dst = {16'h0A0B, $urandom()};
        1: et  = 16'h86DD;
        2: ht  = 16'h0006;
        3: pt  = 16'h86DD;
        4: hl  = 8'h08;
        5: pl  = 8'h10;
        6: opc = 16'($urandom_range(3, 9));
        7: tpa = $urandom() | 32'h1;
        8: err = 6'($urandom_range(1, 63));
        default: ;
      endcase
      if (c == 7 && tpa == LIP) tpa = ~LIP;
      build(dst, et, ht, pt, hl, pl, opc, {16'h0, $urandom()}, $urandom(), tpa);
      ok = model_ok(err, nb);
      send(nb, 1'b1, err, 1'($urandom_range(0, 1)));
      after_frame(ok, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
